// File: rtl/second_game_sequencer.sv
// Round controller for the obstacle-dodge game: state sequencing, accelerating
// scroll tick, hole-size schedule, score counting and per-round engine clear.
module second_game_sequencer #(
   parameter int unsigned TICK_PERIOD_INIT = 32768,
   parameter int unsigned TICK_PERIOD_MIN  = 4096,
   parameter int unsigned TICK_PERIOD_STEP = 1024,
   parameter int unsigned HOLE_INIT        = 75,
   parameter int unsigned HOLE_MIN         = 40,
   parameter int unsigned PASSES_PER_STEP  = 4,
   parameter int unsigned COUNTDOWN_FRAMES = 180,
   parameter int unsigned GAMEOVER_FRAMES  = 120,
   parameter int unsigned SCORE_W          = 10
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               i_start,
   input  logic               i_frame_end,
   input  logic               i_collision,
   input  logic               i_obstacle_passed,
   output logic [1:0]         o_state,
   output logic               o_engine_clear,
   output logic               o_scroll_tick,
   output logic [9:0]         o_hole_size,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_is_gameover
);

   localparam int unsigned HW   = 10;
   localparam int unsigned PW   = $clog2(TICK_PERIOD_INIT + TICK_PERIOD_STEP + 1);
   localparam int unsigned FMAX = (COUNTDOWN_FRAMES > GAMEOVER_FRAMES) ? COUNTDOWN_FRAMES
                                                                       : GAMEOVER_FRAMES;
   localparam int unsigned FW   = $clog2(FMAX + 1);
   localparam int unsigned NW   = $clog2(PASSES_PER_STEP + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      RUN       = 2'd2,
      GAMEOVER  = 2'd3
   } state_t;

   state_t        state;
   logic [PW-1:0] period;
   logic [PW-1:0] tick_cnt;
   logic [FW-1:0] frame_cnt;
   logic [NW-1:0] pass_cnt;

   logic          wrap;
   logic          step_done;
   logic          round_start;
   logic [PW-1:0] period_next;

   // A count already past a freshly shortened period wraps on the next cycle.
   assign wrap        = (tick_cnt >= (period - PW'(1)));
   assign step_done   = (pass_cnt == NW'(PASSES_PER_STEP - 1));
   // Clamp before subtracting so the period can never underflow.
   assign period_next = (period < PW'(TICK_PERIOD_MIN + TICK_PERIOD_STEP))
                        ? PW'(TICK_PERIOD_MIN) : (period - PW'(TICK_PERIOD_STEP));
   assign round_start = i_start && ((state == IDLE) ||
                                    ((state == GAMEOVER) && (frame_cnt == '0)));

   assign o_state = state;

   // Round sequencing, tick generation, difficulty schedule and score.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state          <= IDLE;
         o_engine_clear <= 1'b0;
         o_scroll_tick  <= 1'b0;
         o_hole_size    <= HW'(HOLE_INIT);
         o_score        <= '0;
         o_is_gameover  <= 1'b0;
         period         <= PW'(TICK_PERIOD_INIT);
         tick_cnt       <= '0;
         frame_cnt      <= '0;
         pass_cnt       <= '0;
      end else begin
         o_engine_clear <= 1'b0;
         o_scroll_tick  <= 1'b0;
         if (round_start) begin
            state          <= COUNTDOWN;
            o_engine_clear <= 1'b1;
            o_is_gameover  <= 1'b0;
            frame_cnt      <= FW'(COUNTDOWN_FRAMES);
            o_hole_size    <= HW'(HOLE_INIT);
            period         <= PW'(TICK_PERIOD_INIT);
            o_score        <= '0;
            pass_cnt       <= '0;
         end else begin
            case (state)
               COUNTDOWN: begin
                  if (i_frame_end) begin
                     frame_cnt <= frame_cnt - FW'(1);
                     if (frame_cnt == FW'(1)) begin
                        state    <= RUN;
                        tick_cnt <= '0;
                     end
                  end
               end
               RUN: begin
                  // The tick from a wrap is emitted even if a collision ends the round.
                  o_scroll_tick <= wrap;
                  tick_cnt      <= wrap ? '0 : (tick_cnt + PW'(1));
                  if (i_collision) begin
                     state         <= GAMEOVER;
                     o_is_gameover <= 1'b1;
                     frame_cnt     <= FW'(GAMEOVER_FRAMES);
                  end else if (i_obstacle_passed) begin
                     if (o_score != '1) begin
                        o_score <= o_score + SCORE_W'(1);
                     end
                     if (step_done) begin
                        pass_cnt <= '0;
                        period   <= period_next;
                        if (o_hole_size > HW'(HOLE_MIN)) begin
                           o_hole_size <= o_hole_size - HW'(1);
                        end
                     end else begin
                        pass_cnt <= pass_cnt + NW'(1);
                     end
                  end
               end
               GAMEOVER: begin
                  if (i_frame_end && (frame_cnt != '0)) begin
                     frame_cnt <= frame_cnt - FW'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: doc/second_game_sequencer.md
# second_game_sequencer

Round controller for the second (obstacle-dodge) game. It owns the game state (idle, countdown, run, game over) and generates the obstacle scroll tick at a programmable, accelerating period. It schedules hole-size shrinkage, counts score from obstacle-pass events, and produces the one-cycle engine clear on every new round. It sits between the input/video-timing logic and the second game engine, replacing the engine's free-running timer and hole-size logic with a centrally sequenced schedule.

## Interface
- TICK_PERIOD_INIT, 32768: clock cycles between scroll ticks at round start.
- TICK_PERIOD_MIN, 4096: floor for the tick period.
- TICK_PERIOD_STEP, 1024: period decrement per difficulty step.
- HOLE_INIT, 75: hole half-width at round start.
- HOLE_MIN, 40: floor for the hole half-width.
- PASSES_PER_STEP, 4: obstacle passes per difficulty step.
- COUNTDOWN_FRAMES, 180: frames spent in COUNTDOWN.
- GAMEOVER_FRAMES, 120: frames GAMEOVER must last before a restart is accepted.
- SCORE_W, 10: score width.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  reset; **synchronous, active-low**.
- i_start  in  1  start request pulse (debounced button/mouse click).
- i_frame_end  in  1  one-cycle pulse per video frame.
- i_collision  in  1  ball/obstacle overlap, level.
- i_obstacle_passed  in  1  one-cycle pulse when an obstacle respawns at the top.
- o_state  out  2  encoding: 0 IDLE, 1 COUNTDOWN, 2 RUN, 3 GAMEOVER.
- o_engine_clear  out  1  one-cycle pulse that reloads obstacle positions.
- o_scroll_tick  out  1  one-cycle pulse advancing obstacles by 1 px.
- o_hole_size  out  10  current hole half-width.
- o_score  out  SCORE_W  obstacles passed this round.
- o_is_gameover  out  1  high in GAMEOVER.

## Operation
- Reset (arst_n low at a clk edge) has the following effects:
  - state IDLE, all pulses 0;
  - o_hole_size = HOLE_INIT, period = TICK_PERIOD_INIT;
  - o_score = 0, tick counter 0, frame counter 0, pass counter 0.
- IDLE: i_start → COUNTDOWN. The same transition asserts o_engine_clear for one cycle, loads the frame counter with COUNTDOWN_FRAMES, and restores hole, period, score and pass counter to their initial values.
- COUNTDOWN:
  - The frame counter decrements on each i_frame_end.
  - When i_frame_end arrives with the counter at 1, go to RUN and clear the tick counter.
  - i_start and i_collision are ignored.
- RUN, tick counter:
  - Counts clk cycles.
  - At count == period−1 it wraps to 0 and o_scroll_tick pulses in the next cycle.
- RUN, obstacle passes: each i_obstacle_passed increments o_score, saturating at all-ones, and increments the pass counter.
- RUN, difficulty step: when the pass counter reaches PASSES_PER_STEP it clears, and:
  - o_hole_size drops by 1 if it is above HOLE_MIN;
  - period drops by TICK_PERIOD_STEP, clamped to TICK_PERIOD_MIN. Never underflow: if period − step < MIN, load MIN.
  - The new period applies at the next wrap. The in-flight count is not truncated, except when the count already exceeds the new period−1; then it wraps at the next cycle.
- RUN, collision: i_collision high at any edge → GAMEOVER, and the frame counter loads GAMEOVER_FRAMES. i_start is ignored in RUN.
- GAMEOVER:
  - No ticks.
  - o_score and o_hole_size are frozen.
  - The frame counter decrements on i_frame_end down to 0.
  - i_start while the counter is 0 → COUNTDOWN, with the same actions as the IDLE→COUNTDOWN transition. i_start while the counter is nonzero is dropped, not queued.
- Simultaneous events:
  - Collision and obstacle_passed in the same cycle: collision wins, and the score is not incremented.
  - Collision in the cycle a wrap occurs: the tick pulse registered from that wrap is still emitted in the following cycle. No further ticks follow.
  - Pass that completes a step in the same cycle as a wrap: the wrap uses the old period.
- Reset mid-round: returns to IDLE within the reset cycle. o_engine_clear is not asserted by reset.

## Timing
- Every output is registered.
- o_state changes the cycle after the triggering input edge.
- o_engine_clear is high in the first cycle in which o_state == 1.
- First o_scroll_tick arrives TICK_PERIOD_INIT cycles after o_state becomes 2.
- Ticks are spaced exactly by period (one-cycle pulses).
- o_score and o_hole_size update one cycle after i_obstacle_passed.
- o_is_gameover == (o_state == 3) in every cycle.

## Test plan
Directed scenarios use TICK_PERIOD_INIT=16, TICK_PERIOD_MIN=4, TICK_PERIOD_STEP=4, COUNTDOWN_FRAMES=3, GAMEOVER_FRAMES=2, PASSES_PER_STEP=4, HOLE_INIT=43, HOLE_MIN=40.
- Reset then i_start → o_engine_clear single pulse; o_state 1; after 3 i_frame_end, o_state 2; ticks exactly 16 cycles apart, the first 16 cycles after entering RUN.
- 4 passes → o_score 4, o_hole_size 42, spacing 12 after the next wrap. 16 passes → hole 40, period 4. 20 passes → hole 40, period 4 (both clamped).
- i_collision during RUN → o_state 3 next cycle, ticks stop, score frozen. i_start before 2 frames → ignored. i_start after 2 frames → o_state 1 with score 0, hole 43, clear pulse.
- Collision and pass in the same cycle → GAMEOVER, score unchanged.
- i_collision held high during COUNTDOWN → remains COUNTDOWN; reaching RUN with collision still high → GAMEOVER one cycle later.
- Score saturation with SCORE_W=3: 9 passes → o_score 7. Reset asserted mid-RUN → o_state 0, outputs at reset values, no o_engine_clear.
